loop_track_recorder: RTL
========================

// Module: loop_track_recorder
// PURPOSE
//  Looper stage directly downstream of the filter-select stage. Consumes the
//  filtered stereo sample stream and records one loop into on-chip RAM.
//  Replays the loop continuously, optionally overdubs onto it, and mixes the
//  playback with live input. Drives the codec DAC sample words.
// PARAMETERS
//  DEPTH   16384  max loop length in stereo samples (power of 2)
//  ADDR_W  14     log2(DEPTH)
//  SAMPLE_W 32    per-channel sample width, two's complement
// PORTS
//  AUD_BCLK                 in   1         sole clock, all logic on rising edge
//  reset                    in   1         synchronous, active-high
//  AUD_DACLRCK              in   1         codec frame clock, async to logic, sampled
//  left_channel_audio_in    in   SAMPLE_W  filtered left sample
//  right_channel_audio_in   in   SAMPLE_W  filtered right sample
//  cmd_record               in   1         1-cycle pulse: start record / toggle overdub
//  cmd_play                 in   1         1-cycle pulse: start playback
//  cmd_stop                 in   1         1-cycle pulse: stop
//  left_channel_audio_out   out  SAMPLE_W  mixed left sample, registered
//  right_channel_audio_out  out  SAMPLE_W  mixed right sample, registered
//  loop_state               out  2         00 IDLE, 01 RECORD, 10 PLAY, 11 OVERDUB
//  loop_length              out  ADDR_W+1  recorded length in samples (0 = no loop)
//  loop_position            out  ADDR_W    current RAM address
// BEHAVIOUR
//  Reset: state IDLE; loop_length=0; loop_position=0; both outputs=0; RAM contents kept.
//  Strobe: AUD_DACLRCK goes through a 2-flop synchroniser, then a rising-edge detector.
//   The result is a 1-cycle sample_tick. All datapath actions happen only on sample_tick.
//  Command priority when pulses coincide: stop > record > play. Commands act immediately.
//  IDLE: out = in (passthrough, 2-cycle latency).
//   record -> RECORD, position=0.
//   play -> PLAY only if loop_length!=0; otherwise ignored.
//  RECORD: on tick, write {L,R} to RAM[position], then position++. out = in.
//   stop -> PLAY with loop_length=position; if position==0, go to IDLE instead.
//   Position reaching DEPTH forces PLAY with loop_length=DEPTH. No wrap in RECORD.
//   play is ignored in RECORD.
//  PLAY: on tick, read RAM[position]. RAM read latency is 1 cycle.
//   The cycle after the read: out = sat(in + stored), per channel.
//   position increments and wraps to 0 when position+1 == loop_length.
//   record -> OVERDUB. stop -> IDLE, position=0.
//  OVERDUB: same read/mix as PLAY. On the same cycle the mix is produced, write
//   sat(in + stored) back to RAM[same position]. Read-modify-write completes within one tick.
//   record or play -> PLAY. stop -> IDLE.
//  Saturation: the signed sum is computed at SAMPLE_W+1 bits.
//   Clamp to 0x7FFFFFFF or 0x80000000 on overflow.
//  Latency: outputs update exactly 2 AUD_BCLK cycles after sample_tick. They hold until the next update.
//  Reset mid-record: loop discarded (loop_length=0); RAM not cleared.
//  A command arriving on the same cycle as sample_tick takes effect before that tick's datapath action.
// STRUCTURE
//  Shared package loop_pkg: loop_state_t enum with the 4 states and their encodings,
//   SAMPLE_W, and sat_add function.
//  Sub-module loop_sample_ram: simple dual-port RAM, 2*SAMPLE_W wide, DEPTH deep,
//   1-cycle registered read. Written so it infers block RAM.
//  Top level holds the synchroniser/edge detector, FSM, pointer, and mix/saturate pipeline.
// TESTING
//  1. Record 4 ticks of L=1..4, R=-1..-4, then stop.
//     -> loop_length=4, state PLAY. With in=0, out cycles L 1,2,3,4,1 and R -1..-4,-1.
//  2. Play with in=L 0x7FFFFFF0 over stored 0x20.
//     -> out L=0x7FFFFFFF. Negative case: 0x80000010 + (-0x20) -> out 0x80000000.
//  3. Overdub one full pass with in=10 over loop {1,2,3,4}, then play with in=0.
//     -> out {11,12,13,14}.
//  4. Record DEPTH+3 ticks with no stop.
//     -> auto PLAY after DEPTH ticks, loop_length=DEPTH, position wraps at DEPTH-1 -> 0.
//  5. cmd_stop and cmd_record in the same cycle during PLAY -> IDLE.
//     cmd_play while loop_length=0 -> stays IDLE.
//  6. Assert reset mid-RECORD after 3 ticks.
//     -> next cycle: IDLE, loop_length=0, outs=0. cmd_play is then ignored.

Source files
------------

// File: rtl/loop_pkg.sv
// Shared types and arithmetic helpers for the loop recorder.
package loop_pkg;

  localparam int SAMPLE_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RECORD  = 2'b01,
    ST_PLAY    = 2'b10,
    ST_OVERDUB = 2'b11
  } loop_state_t;

  // Signed add evaluated one bit wider, clamped to the sample range.
  function automatic logic signed [SAMPLE_W-1:0] sat_add(
    input logic signed [SAMPLE_W-1:0] a,
    input logic signed [SAMPLE_W-1:0] b
  );
    logic signed [SAMPLE_W:0] sum;
    sum = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
    if (sum[SAMPLE_W] != sum[SAMPLE_W-1]) begin
      sat_add = sum[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}}
                              : {1'b0, {(SAMPLE_W-1){1'b1}}};
    end else begin
      sat_add = sum[SAMPLE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/loop_sample_ram.sv
// Simple dual-port loop storage: one write port, one registered read port.
module loop_sample_ram
  import loop_pkg::*;
#(
  parameter int DATA_W = 2 * SAMPLE_W,
  parameter int DEPTH  = 16384,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/loop_track_recorder.sv
// Looper: records one stereo loop into RAM, replays/overdubs it and mixes with live input.
module loop_track_recorder
  import loop_pkg::*;
#(
  parameter int DEPTH  = 16384,
  parameter int ADDR_W = 14
) (
  input  logic                       AUD_BCLK,
  input  logic                       reset,
  input  logic                       AUD_DACLRCK,
  input  logic signed [SAMPLE_W-1:0] left_channel_audio_in,
  input  logic signed [SAMPLE_W-1:0] right_channel_audio_in,
  input  logic                       cmd_record,
  input  logic                       cmd_play,
  input  logic                       cmd_stop,
  output logic signed [SAMPLE_W-1:0] left_channel_audio_out,
  output logic signed [SAMPLE_W-1:0] right_channel_audio_out,
  output logic [1:0]                 loop_state,
  output logic [ADDR_W:0]            loop_length,
  output logic [ADDR_W-1:0]          loop_position
);

  localparam logic [ADDR_W-1:0] POS_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] POS_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LEN_MAX  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W + 1)'(1);

  logic lrck_s1, lrck_s2, lrck_d, sample_tick;

  loop_state_t       state, state_nx, eff_state;
  logic [ADDR_W-1:0] pos, pos_nx, eff_pos;
  logic [ADDR_W:0]   len, len_nx;
  logic              rec_we, rd_en;

  logic signed [SAMPLE_W-1:0] in_l_p0, in_r_p0;
  logic [ADDR_W-1:0]          addr_p0;
  logic                       vld_p0, mix_p0, wb_p0;

  logic [2*SAMPLE_W-1:0]      rdata;
  logic signed [SAMPLE_W-1:0] stored_l, stored_r, mix_l, mix_r;
  logic                       ram_we;
  logic [ADDR_W-1:0]          ram_waddr;
  logic [2*SAMPLE_W-1:0]      ram_wdata;

  // LRCK crosses in through two flops; its rising edge is the sample strobe.
  always_ff @(posedge AUD_BCLK) begin
    if (reset) begin
      lrck_s1 <= 1'b0;
      lrck_s2 <= 1'b0;
      lrck_d  <= 1'b0;
    end else begin
      lrck_s1 <= AUD_DACLRCK;
      lrck_s2 <= lrck_s1;
      lrck_d  <= lrck_s2;
    end
  end

  assign sample_tick = lrck_s2 & ~lrck_d;

  always_ff @(posedge AUD_BCLK) begin
    if (reset) begin
      state <= ST_IDLE;
      pos   <= '0;
      len   <= '0;
    end else begin
      state <= state_nx;
      pos   <= pos_nx;
      len   <= len_nx;
    end
  end

  // Commands resolve first (eff_*), then a coincident tick acts on the result.
  always_comb begin
    eff_state = state;
    eff_pos   = pos;
    len_nx    = len;
    case (state)
      ST_IDLE: begin
        if (cmd_stop) begin
          eff_state = ST_IDLE;
        end else if (cmd_record) begin
          eff_state = ST_RECORD;
          eff_pos   = '0;
          len_nx    = '0;
        end else if (cmd_play && (len != '0)) begin
          eff_state = ST_PLAY;
          eff_pos   = '0;
        end
      end
      ST_RECORD: begin
        if (cmd_stop) begin
          eff_state = (pos == '0) ? ST_IDLE : ST_PLAY;
          len_nx    = {1'b0, pos};
          eff_pos   = '0;
        end
      end
      ST_PLAY: begin
        if (cmd_stop) begin
          eff_state = ST_IDLE;
          eff_pos   = '0;
        end else if (cmd_record) begin
          eff_state = ST_OVERDUB;
        end
      end
      default: begin
        if (cmd_stop) begin
          eff_state = ST_IDLE;
          eff_pos   = '0;
        end else if (cmd_record || cmd_play) begin
          eff_state = ST_PLAY;
        end
      end
    endcase

    state_nx = eff_state;
    pos_nx   = eff_pos;
    rec_we   = 1'b0;
    rd_en    = 1'b0;
    if (sample_tick) begin
      case (eff_state)
        ST_RECORD: begin
          rec_we = 1'b1;
          if (eff_pos == POS_LAST) begin
            state_nx = ST_PLAY;
            len_nx   = LEN_MAX;
            pos_nx   = '0;
          end else begin
            pos_nx = eff_pos + POS_ONE;
          end
        end
        ST_PLAY, ST_OVERDUB: begin
          rd_en  = 1'b1;
          pos_nx = (({1'b0, eff_pos} + LEN_ONE) == len_nx) ? '0 : eff_pos + POS_ONE;
        end
        default: ;
      endcase
    end
  end

  // Stage p0: capture live input and read address alongside the RAM read.
  always_ff @(posedge AUD_BCLK) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      mix_p0 <= 1'b0;
      wb_p0  <= 1'b0;
    end else begin
      vld_p0 <= sample_tick;
      mix_p0 <= rd_en;
      wb_p0  <= rd_en && (eff_state == ST_OVERDUB);
    end
  end

  always_ff @(posedge AUD_BCLK) begin
    if (sample_tick) begin
      in_l_p0 <= left_channel_audio_in;
      in_r_p0 <= right_channel_audio_in;
      addr_p0 <= eff_pos;
    end
  end

  assign stored_l = rdata[2*SAMPLE_W-1:SAMPLE_W];
  assign stored_r = rdata[SAMPLE_W-1:0];
  assign mix_l    = sat_add(in_l_p0, stored_l);
  assign mix_r    = sat_add(in_r_p0, stored_r);

  // Record writes at the tick; overdub writes the mix back one cycle later.
  assign ram_we    = rec_we | wb_p0;
  assign ram_waddr = wb_p0 ? addr_p0 : eff_pos;
  assign ram_wdata = wb_p0 ? {mix_l, mix_r} : {left_channel_audio_in, right_channel_audio_in};

  loop_sample_ram #(
    .DATA_W(2 * SAMPLE_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (AUD_BCLK),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (rd_en),
    .raddr(eff_pos),
    .rdata(rdata)
  );

  // Stage p1: mixed or passthrough sample lands in the output registers.
  always_ff @(posedge AUD_BCLK) begin
    if (reset) begin
      left_channel_audio_out  <= '0;
      right_channel_audio_out <= '0;
    end else if (vld_p0) begin
      left_channel_audio_out  <= mix_p0 ? mix_l : in_l_p0;
      right_channel_audio_out <= mix_p0 ? mix_r : in_r_p0;
    end
  end

  assign loop_state    = state;
  assign loop_length   = len;
  assign loop_position = pos;

endmodule
